spi_master_arbiter: RTL and testbench
=====================================

Name: spi_master_arbiter

Overview:
- Round-robin scheduler that shares one spi_master between NUM_REQ system-side requesters.
- Owns the master's t_start, d_in and t_size inputs and captures its d_out.
- Decodes the master's single cs into per-slave active-low chip selects.
- Detects transaction completion from the master's cs returning high, and guards it with a timeout.

Parameters:
- NUM_REQ, 4, number of requesters/slaves (2..8).
- reg_width, 8, SPI word width; must match the attached spi_master.
- counter_width, $clog2(reg_width), width base for size fields (size field is counter_width+1 bits).
- TIMEOUT, 64, sys_clk cycles allowed per phase before abort.

Ports:
- sys_clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  level request per requester; held until its done pulse.
- wdata  in  NUM_REQ*reg_width  packed write words; requester i at [i*reg_width +: reg_width].
- tsize  in  NUM_REQ*(counter_width+1)  packed bit counts per requester.
- ack  out  NUM_REQ  one-cycle pulse when a request is accepted.
- done  out  NUM_REQ  one-cycle pulse when a request completes, whether success or error.
- rdata  out  reg_width  read word; valid in the done cycle, held until the next done.
- err  out  1  one-cycle pulse coincident with done on reject or timeout.
- m_t_start  out  1  to master t_start.
- m_d_in  out  reg_width  to master d_in.
- m_t_size  out  counter_width+1  to master t_size.
- m_d_out  in  reg_width  from master d_out.
- m_cs  in  1  from master cs (low = busy).
- slave_cs_n  out  NUM_REQ  per-slave chip select, active low.

Behaviour:
- Reset (rstn low, asynchronous): FSM=IDLE, rr pointer=NUM_REQ-1, ack=0, done=0, err=0, rdata=0, m_t_start=0, m_d_in=0, m_t_size=0, grant_valid=0, timer=0.
  - slave_cs_n is all ones because grant_valid is 0.
  - Reset mid-transaction abandons it; no done is issued.
- FSM states:
  - IDLE: if any req is set, select the first set bit scanning from rr+1 upward with wrap. Latch idx, wdata[idx] into m_d_in and tsize[idx] into m_t_size. Pulse ack[idx]. Set rr=idx. Go to CHECK.
  - CHECK: if m_t_size==0 or m_t_size>reg_width, pulse done[idx] and err, return to IDLE, and leave the master untouched (rdata unchanged). Otherwise set grant_valid=1, m_t_start=1, timer=0, and go to START.
  - START: hold m_t_start=1 until m_cs is sampled low, then drop m_t_start, timer=0, and go to BUSY. If timer reaches TIMEOUT-1, go to ABORT.
  - BUSY: wait for m_cs sampled high. Then capture rdata=m_d_out, pulse done[idx], clear grant_valid, and go to IDLE. If timer reaches TIMEOUT-1, go to ABORT.
  - ABORT: m_t_start=0, grant_valid=0, pulse done[idx] and err, rdata unchanged, go to IDLE.
- Latency:
  - Accept to m_t_start: 2 cycles (IDLE to CHECK to START).
  - m_cs high to done: 1 cycle.
  - Minimum gap between consecutive grants: 1 IDLE cycle.
- slave_cs_n[i] = ~(grant_valid && idx==i && !m_cs). This is combinational from m_cs and registered state so it tracks the master's cs edges exactly; at most one bit is ever low.
- Inputs are sampled only at acceptance. Changes to wdata or tsize mid-transaction have no effect. A req dropped before done is ignored; the transaction completes anyway.
- Simultaneous requests are served in rotating order, so with all NUM_REQ requesting continuously each requester is served exactly once per NUM_REQ grants.
- done and ack never fire for the same requester in the same cycle. A new ack can fire in the cycle after done.
- Timer is a saturating counter of $clog2(TIMEOUT)+1 bits, cleared on every state entry.

Decomposition:
- Shared package spi_pkg holds:
  - the FSM state encoding (IDLE, CHECK, START, BUSY, ABORT, 3 bits);
  - default widths REG_WIDTH=8 and DEFAULT_TIMEOUT=64;
  - the tsize legality rule as a constant function.
- One sub-module, rr_arbiter: parameter N. Inputs req, last grant pointer, enable. Outputs grant index and a valid flag. Purely combinational priority rotate; reused by later SPI multi-slave blocks.

Test Plan:
- Single request: req=4'b0010, wdata[1]=8'hA5, tsize[1]=8, model slave returns 8'h3C -> ack[1] pulses, slave_cs_n=4'b1101 exactly while m_cs low, then done[1], rdata=8'h3C, err=0.
- All four request at once after reset -> grants in order 0,1,2,3, then 0 again if still requesting; slave_cs_n never has two bits low.
- Illegal size: tsize[2]=0, then tsize[2]=9 -> ack[2] then done[2] with err both times; m_t_start stays 0; slave_cs_n stays 4'b1111; rdata unchanged.
- Stuck master: tie m_cs=1 -> m_t_start held for 64 cycles, then done plus err, FSM back to IDLE; the next request is served normally.
- rstn pulsed low mid-BUSY -> all outputs reach reset values immediately (asynchronously); no done pulse; the post-reset request is granted starting from requester 0.
- Fairness stress: random req over 10k cycles -> no requester waits more than NUM_REQ-1 intervening grants; rdata matches the scoreboard for every done without err.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_pkg -- shared SPI FSM encoding, default widths, size rule.  Rev 1.0
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int REG_WIDTH       = 8;
  localparam int DEFAULT_TIMEOUT = 64;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_START = 3'd2,
    S_BUSY  = 3'd3,
    S_ABORT = 3'd4
  } arb_state_e;

  // A transfer must move at least one bit and no more bits than the word holds.
  function automatic logic tsize_legal(input int size, input int width);
    return (size != 0) && (size <= width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter -- combinational round-robin pick after the last grant.  Rev 1.0
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  input  logic                 en_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 valid_o
);

  localparam int IW = $clog2(N);

  int pos;

  // The most recent winner is scanned last, which gives the rotation.
  always_comb begin
    idx_o   = last_i;
    valid_o = 1'b0;
    pos     = 0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(last_i) + k) % N;
      if (en_i && !valid_o && req_i[IW'(pos)]) begin
        valid_o = 1'b1;
        idx_o   = IW'(pos);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_master_arbiter -- round-robin sharing of one spi_master.  Rev 1.0
// ---------------------------------------------------------------------------
module spi_master_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int reg_width     = REG_WIDTH,
  parameter int counter_width = $clog2(reg_width),
  parameter int TIMEOUT       = DEFAULT_TIMEOUT
) (
  input  logic                                 sys_clk,
  input  logic                                 rstn,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ*reg_width-1:0]         wdata,
  input  logic [NUM_REQ*(counter_width+1)-1:0] tsize,
  output logic [NUM_REQ-1:0]                   ack,
  output logic [NUM_REQ-1:0]                   done,
  output logic [reg_width-1:0]                 rdata,
  output logic                                 err,
  output logic                                 m_t_start,
  output logic [reg_width-1:0]                 m_d_in,
  output logic [counter_width:0]               m_t_size,
  input  logic [reg_width-1:0]                 m_d_out,
  input  logic                                 m_cs,
  output logic [NUM_REQ-1:0]                   slave_cs_n
);

  localparam int            IW    = $clog2(NUM_REQ);
  localparam int            SW    = counter_width + 1;
  localparam int            TW    = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 err_q, err_d;
  logic [reg_width-1:0] rdata_q, rdata_d;
  logic                 t_start_q, t_start_d;
  logic [reg_width-1:0] d_in_q, d_in_d;
  logic [SW-1:0]        t_size_q, t_size_d;
  logic                 gv_q, gv_d;
  logic [TW-1:0]        timer_q, timer_d;

  logic [IW-1:0]        arb_idx;
  logic                 arb_valid;
  logic                 timeout;
  logic [reg_width-1:0] wdata_a [NUM_REQ];
  logic [SW-1:0]        tsize_a [NUM_REQ];

  // rr_q doubles as the index of the requester currently being served.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign wdata_a[g]    = wdata[g*reg_width +: reg_width];
    assign tsize_a[g]    = tsize[g*SW +: SW];
    assign slave_cs_n[g] = ~(gv_q && (rr_q == IW'(g)) && !m_cs);
  end

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .req_i   (req),
    .last_i  (rr_q),
    .en_i    (state_q == S_IDLE),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign timeout = (timer_q == TLAST);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    ack_d     = '0;
    done_d    = '0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    t_start_d = t_start_q;
    d_in_d    = d_in_q;
    t_size_d  = t_size_q;
    gv_d      = gv_q;
    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          rr_d           = arb_idx;
          d_in_d         = wdata_a[arb_idx];
          t_size_d       = tsize_a[arb_idx];
          ack_d[arb_idx] = 1'b1;
          state_d        = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!tsize_legal(int'(t_size_q), reg_width)) begin
          done_d[rr_q] = 1'b1;
          err_d        = 1'b1;
          state_d      = S_IDLE;
        end else begin
          gv_d      = 1'b1;
          t_start_d = 1'b1;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (!m_cs) begin
          t_start_d = 1'b0;
          state_d   = S_BUSY;
        end else if (timeout) begin
          t_start_d = 1'b0;
          gv_d      = 1'b0;
          state_d   = S_ABORT;
        end
      end
      S_BUSY: begin
        if (m_cs) begin
          rdata_d      = m_d_out;
          done_d[rr_q] = 1'b1;
          gv_d         = 1'b0;
          state_d      = S_IDLE;
        end else if (timeout) begin
          gv_d    = 1'b0;
          state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        t_start_d    = 1'b0;
        gv_d         = 1'b0;
        done_d[rr_q] = 1'b1;
        err_d        = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Restart the phase timer on every state change; otherwise count and saturate.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = timer_q;
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      rr_q      <= IW'(NUM_REQ - 1);
      ack_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      t_start_q <= 1'b0;
      d_in_q    <= '0;
      t_size_q  <= '0;
      gv_q      <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      t_start_q <= t_start_d;
      d_in_q    <= d_in_d;
      t_size_q  <= t_size_d;
      gv_q      <= gv_d;
      timer_q   <= timer_d;
    end
  end

  assign ack       = ack_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign m_t_start = t_start_q;
  assign m_d_in    = d_in_q;
  assign m_t_size  = t_size_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spi_master_arbiter -- table, corner sequences and random stress.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_spi_master_arbiter;

  localparam int         N     = 4;
  localparam int         W     = 8;
  localparam int         SW    = 4;
  localparam logic [7:0] XMASK = 8'h99;

  logic          sys_clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  req;
  logic [N*W-1:0]  wdata;
  logic [N*SW-1:0] tsize;
  logic [N-1:0]  ack, done, slave_cs_n;
  logic [W-1:0]  rdata, m_d_in, m_d_out;
  logic          err, m_t_start, m_cs;
  logic [SW-1:0] m_t_size;
  logic          stuck;

  int checks = 0;
  int errors = 0;

  spi_master_arbiter #(
    .NUM_REQ(N), .reg_width(W), .counter_width(3), .TIMEOUT(64)
  ) dut (
    .sys_clk(sys_clk), .rstn(rstn), .req(req), .wdata(wdata), .tsize(tsize),
    .ack(ack), .done(done), .rdata(rdata), .err(err),
    .m_t_start(m_t_start), .m_d_in(m_d_in), .m_t_size(m_t_size),
    .m_d_out(m_d_out), .m_cs(m_cs), .slave_cs_n(slave_cs_n)
  );

  always #5 sys_clk = ~sys_clk;

  // Slave-side master model: random start latency, cs low for t_size+0..2 cycles,
  // then returns d_in ^ 0x99 as the received word.
  int mphase, mcnt;
  always @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      m_cs <= 1'b1; m_d_out <= '0; mphase <= 0; mcnt <= 0;
    end else if (stuck) begin
      m_cs <= 1'b1; mphase <= 0;
    end else begin
      case (mphase)
        0: if (m_t_start) begin mphase <= 1; mcnt <= int'($urandom_range(0, 2)); end
        1: if (mcnt == 0) begin
             m_cs <= 1'b0; mphase <= 2; mcnt <= int'(m_t_size) + int'($urandom_range(0, 2));
           end else mcnt <= mcnt - 1;
        default: if (mcnt <= 1) begin
             m_cs <= 1'b1; m_d_out <= m_d_in ^ XMASK; mphase <= 0;
           end else mcnt <= mcnt - 1;
      endcase
    end
  end

  initial begin
    #600000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge sys_clk);
    rstn = 1'b0; req = '0;
    repeat (2) @(negedge sys_clk);
    rstn = 1'b1;
  endtask

  task automatic run_txn(input int idx, input logic [7:0] wd, input logic [3:0] ts,
                         input logic exp_err, input logic [7:0] exp_rd, input string nm);
    int ack_c, start_c, rise_c, done_c;
    logic prev_cs, cs_ok, err_ok;
    logic [N-1:0] exp_cs;
    ack_c = -1; start_c = -1; rise_c = -1; done_c = -1;
    prev_cs = 1'b1; cs_ok = 1'b1; err_ok = 1'b1;
    wdata[idx*W +: W] = wd; tsize[idx*SW +: SW] = ts; req[idx] = 1'b1;
    for (int c = 0; c < 300 && done_c < 0; c++) begin
      @(negedge sys_clk);
      if (ack != '0 && ack_c < 0) begin
        ack_c = c;
        check($sformatf("%s ack", nm), ack, oh(idx));
        wdata[idx*W +: W] = ~wd; tsize[idx*SW +: SW] = 4'd5;
      end
      if (m_t_start && start_c < 0) start_c = c;
      if (!prev_cs && m_cs && rise_c < 0) rise_c = c;
      exp_cs = (!m_cs && ack_c >= 0) ? ~oh(idx) : '1;
      if (slave_cs_n !== exp_cs) cs_ok = 1'b0;
      if (done != '0) begin
        done_c = c;
        check($sformatf("%s done", nm), done, oh(idx));
        check($sformatf("%s err", nm), err, exp_err);
        check($sformatf("%s rdata", nm), rdata, exp_rd);
        req[idx] = 1'b0;
      end else if (err) err_ok = 1'b0;
      prev_cs = m_cs;
    end
    check($sformatf("%s done seen", nm), done_c >= 0, 1);
    check($sformatf("%s slave_cs_n", nm), cs_ok, 1);
    check($sformatf("%s err only with done", nm), err_ok, 1);
    if (exp_err) begin
      check($sformatf("%s t_start stays low", nm), start_c < 0, 1);
      check($sformatf("%s reject latency", nm), done_c - ack_c, 1);
    end else begin
      check($sformatf("%s ack to t_start", nm), start_c - ack_c, 1);
      check($sformatf("%s cs high to done", nm), done_c - rise_c, 1);
    end
  endtask

  typedef struct {
    int         idx;
    logic [7:0] wd;
    logic [3:0] ts;
    logic       exp_err;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int hi, last_hi, done_c, got;
    logic cs_ok, seen, one_ok;
    int gl[$];

    tbl[0] = '{1, 8'hA5, 4'd8,  1'b0, 8'h3C};
    tbl[1] = '{2, 8'h11, 4'd0,  1'b1, 8'h3C};
    tbl[2] = '{2, 8'h22, 4'd9,  1'b1, 8'h3C};
    tbl[3] = '{0, 8'h5A, 4'd1,  1'b0, 8'hC3};
    tbl[4] = '{3, 8'hFF, 4'd4,  1'b0, 8'h66};
    tbl[5] = '{2, 8'h00, 4'd15, 1'b1, 8'h66};
    tbl[6] = '{2, 8'h00, 4'd8,  1'b0, 8'h99};

    rstn = 1'b0; req = '0; wdata = '0; tsize = '0; stuck = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset ack", ack, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset rdata", rdata, 0);
    check("reset m_t_start", m_t_start, 0);
    check("reset m_d_in", m_d_in, 0);
    check("reset m_t_size", m_t_size, 0);
    check("reset slave_cs_n", slave_cs_n, 4'hF);
    rstn = 1'b1;

    for (int v = 0; v < 7; v++)
      run_txn(tbl[v].idx, tbl[v].wd, tbl[v].ts, tbl[v].exp_err, tbl[v].exp_rd,
              $sformatf("vec%0d", v));

    // Master never lowers cs: START must time out after 64 cycles.
    stuck = 1'b1;
    wdata[0 +: W] = 8'h42; tsize[0 +: SW] = 4'd8; req = 4'b0001;
    hi = 0; last_hi = -1; done_c = -1; cs_ok = 1'b1;
    for (int c = 0; c < 300 && done_c < 0; c++) begin
      @(negedge sys_clk);
      if (m_t_start) begin hi++; last_hi = c; end
      if (slave_cs_n !== 4'hF) cs_ok = 1'b0;
      if (done != '0) begin
        done_c = c;
        check("timeout done", done, 4'b0001);
        check("timeout err", err, 1);
        check("timeout rdata kept", rdata, 8'h99);
      end
    end
    req = '0; stuck = 1'b0;
    check("timeout t_start cycles", hi, 64);
    check("timeout done after abort", done_c - last_hi, 2);
    check("timeout slave_cs_n", cs_ok, 1);
    run_txn(0, 8'h3C, 4'd3, 1'b0, 8'hA5, "post-timeout");

    // Asynchronous reset in the middle of BUSY.
    wdata[2*W +: W] = 8'h77; tsize[2*SW +: SW] = 4'd8; req = 4'b0100;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge sys_clk);
      if (!m_cs) seen = 1'b1;
    end
    check("midbusy cs low seen", seen, 1);
    @(negedge sys_clk);
    #2 rstn = 1'b0;
    #1;
    check("async ack", ack, 0);
    check("async done", done, 0);
    check("async err", err, 0);
    check("async rdata", rdata, 0);
    check("async m_t_start", m_t_start, 0);
    check("async m_d_in", m_d_in, 0);
    check("async m_t_size", m_t_size, 0);
    check("async slave_cs_n", slave_cs_n, 4'hF);
    req = 4'b1001; tsize[0 +: SW] = 4'd4; tsize[3*SW +: SW] = 4'd4;
    repeat (2) begin
      @(negedge sys_clk);
      check("reset hold no done", done, 0);
    end
    rstn = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge sys_clk);
      if (ack != '0) got = int'(ack);
    end
    check("post-reset first grant", got, 4'b0001);

    // All four requesting continuously from reset.
    do_reset();
    for (int i = 0; i < N; i++) begin
      wdata[i*W +: W] = 8'(8'h10 + i); tsize[i*SW +: SW] = 4'd8;
    end
    req = '1; one_ok = 1'b1;
    for (int c = 0; c < 600 && gl.size() < 5; c++) begin
      @(negedge sys_clk);
      for (int i = 0; i < N; i++) if (ack[i]) gl.push_back(i);
      if ($countones(~slave_cs_n) > 1) one_ok = 1'b0;
    end
    check("all-four grant count", gl.size(), 5);
    for (int k = 0; k < gl.size(); k++)
      check($sformatf("all-four grant %0d", k), gl[k], k % N);
    check("all-four single cs", one_ok, 1);

    // Random stress against a transaction-level model.
    do_reset();
    begin
      int st[N];
      int waits[N];
      int act_idx, ptr, g, age, max_age;
      logic [7:0] exp_wd, last_rd, exp_rd;
      logic [3:0] ts;
      logic exp_e, exp_ack;
      logic [N-1:0] req_prev, exp_cs;
      for (int i = 0; i < N; i++) begin st[i] = 0; waits[i] = 0; end
      act_idx = -1; ptr = N - 1; age = 0; max_age = 0;
      last_rd = '0; exp_wd = '0; exp_e = 1'b0; exp_ack = 1'b0; req_prev = '0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
        @(negedge sys_clk);
        if (exp_ack) begin
          g = rr_pick(req_prev, ptr);
          check("stress ack", ack, oh(g));
          for (int i = 0; i < N; i++)
            if (i != g && st[i] == 1) begin
              waits[i]++;
              check("stress fairness", waits[i] <= N - 1, 1);
            end
          waits[g] = 0; ptr = g; act_idx = g; st[g] = 2; age = 0;
          exp_wd = wdata[g*W +: W];
          ts = tsize[g*SW +: SW];
          exp_e = (ts == 4'd0) || (ts > 4'd8);
        end else begin
          check("stress no ack", ack, 0);
        end
        if (done != '0) begin
          if (act_idx < 0) begin
            check("stress stray done", done, 0);
          end else begin
            exp_rd = exp_e ? last_rd : (exp_wd ^ XMASK);
            check("stress done", done, oh(act_idx));
            check("stress err", err, exp_e);
            check("stress rdata", rdata, exp_rd);
            last_rd = exp_rd;
            st[act_idx] = 0; req[act_idx] = 1'b0; act_idx = -1;
          end
        end else begin
          check("stress err without done", err, 0);
          if (act_idx >= 0) begin
            age++;
            if (age > max_age) max_age = age;
          end
        end
        exp_cs = (act_idx >= 0 && !m_cs) ? ~oh(act_idx) : '1;
        check("stress slave_cs_n", slave_cs_n, exp_cs);
        for (int i = 0; i < N; i++) begin
          if (st[i] == 0 && $urandom_range(0, 3) == 0) begin
            st[i] = 1; req[i] = 1'b1;
            wdata[i*W +: W] = 8'($urandom);
            if ($urandom_range(0, 5) == 0)
              tsize[i*SW +: SW] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
            else
              tsize[i*SW +: SW] = 4'($urandom_range(1, 8));
          end else if (st[i] == 2) begin
            if ($urandom_range(0, 3) == 0) begin
              wdata[i*W +: W] = 8'($urandom); tsize[i*SW +: SW] = 4'($urandom);
            end
            if (req[i] && $urandom_range(0, 15) == 0) req[i] = 1'b0;
          end
        end
        exp_ack  = (act_idx < 0) && (req != '0);
        req_prev = req;
      end
      check("stress done within bound", max_age <= 300, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
